// File: rtl/thunder_tod_keeper.sv
// Time-of-day keeper disciplined by a Thunderbolt 1PPS and decoded timing packets.
// Packets are validated into a shadow register that is applied, plus one second, on the next PPS.
module thunder_tod_keeper #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int PPS_TIMEOUT = 75000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pps,
  input  logic        i_thunder_packet_dv,
  input  logic [7:0]  i_thunder_year_h,
  input  logic [7:0]  i_thunder_year_l,
  input  logic [7:0]  i_thunder_month,
  input  logic [7:0]  i_thunder_day,
  input  logic [7:0]  i_thunder_hour,
  input  logic [7:0]  i_thunder_minutes,
  input  logic [7:0]  i_thunder_seconds,
  output logic [15:0] o_year,
  output logic [7:0]  o_month,
  output logic [7:0]  o_day,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_minutes,
  output logic [7:0]  o_seconds,
  output logic        o_tick,
  output logic        o_locked,
  output logic        o_resync,
  output logic        o_pkt_err
);

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
  } tod_t;

  typedef enum logic [1:0] {UNSYNC, ARMED, SYNC} state_t;

  // Counter is wide enough for the timeout and for a full nominal second.
  localparam int WD_MAX = (PPS_TIMEOUT > CLK_FREQ_HZ) ? PPS_TIMEOUT : CLK_FREQ_HZ;
  localparam int WD_W   = $clog2(WD_MAX + 1);

  localparam tod_t TOD_RESET = '{year: 16'd2000, month: 8'd1, day: 8'd1,
                                 hour: 8'd0, minutes: 8'd0, seconds: 8'd0};

  function automatic logic [7:0] days_in_month(input logic [15:0] y, input logic [7:0] m);
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
      8'd2:                    return (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
      default:                 return 8'd31;
    endcase
  endfunction

  function automatic tod_t tod_inc(input tod_t t);
    tod_t r;
    r = t;
    if (t.seconds != 8'd59) r.seconds = t.seconds + 8'd1;
    else begin
      r.seconds = 8'd0;
      if (t.minutes != 8'd59) r.minutes = t.minutes + 8'd1;
      else begin
        r.minutes = 8'd0;
        if (t.hour != 8'd23) r.hour = t.hour + 8'd1;
        else begin
          r.hour = 8'd0;
          if (t.day < days_in_month(t.year, t.month)) r.day = t.day + 8'd1;
          else begin
            r.day = 8'd1;
            if (t.month != 8'd12) r.month = t.month + 8'd1;
            else begin
              r.month = 8'd1;
              r.year  = t.year + 16'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  logic           pps_s1, pps_s2, pps_s3, pps_ok, pps_evt;
  logic [1:0]     fill;
  logic           dv_d, pkt_evt, pkt_valid, pkt_ok;
  tod_t           pkt, shadow, tod, shadow_inc, tod_step;
  logic           load_pend, pps_load, pps_step, wd_expire;
  logic [WD_W-1:0] wd;
  state_t         state, state_next;

  assign pkt = {i_thunder_year_h, i_thunder_year_l, i_thunder_month, i_thunder_day,
                i_thunder_hour, i_thunder_minutes, i_thunder_seconds};
  assign pkt_evt    = i_thunder_packet_dv & ~dv_d;
  assign pkt_ok     = pkt_evt & pkt_valid;
  assign shadow_inc = tod_inc(shadow);
  assign tod_step   = tod_inc(tod);
  assign wd_expire  = !pps_evt && (wd == WD_W'(PPS_TIMEOUT - 1));
  assign pps_load   = pps_evt && (state == ARMED || (state == SYNC && load_pend));
  assign pps_step   = pps_evt && state == SYNC && !load_pend;

  always_comb begin
    pkt_valid = (pkt.year >= 16'd2000) && (pkt.year <= 16'd2099) &&
                (pkt.month >= 8'd1) && (pkt.month <= 8'd12) &&
                (pkt.day >= 8'd1) && (pkt.day <= days_in_month(pkt.year, pkt.month)) &&
                (pkt.hour <= 8'd23) && (pkt.minutes <= 8'd59) && (pkt.seconds <= 8'd59);
  end

  // PPS edges are only accepted once the synchronizer has shown a genuine low sample,
  // so a PPS already high at reset release never produces an event.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pps_s1  <= 1'b0;
      pps_s2  <= 1'b0;
      pps_s3  <= 1'b0;
      fill    <= '0;
      pps_ok  <= 1'b0;
      pps_evt <= 1'b0;
      dv_d    <= 1'b0;
      wd      <= '0;
    end else begin
      pps_s1  <= i_pps;
      pps_s2  <= pps_s1;
      pps_s3  <= pps_s2;
      fill    <= {fill[0], 1'b1};
      pps_ok  <= pps_ok | (fill[1] & ~pps_s2);
      pps_evt <= pps_s2 & ~pps_s3 & pps_ok;
      dv_d    <= i_thunder_packet_dv;
      if (pps_evt)                          wd <= '0;
      else if (wd != WD_W'(PPS_TIMEOUT))    wd <= wd + WD_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= UNSYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      UNSYNC:  if (pkt_ok) state_next = ARMED;
      ARMED: begin
        if (pps_evt)        state_next = SYNC;
        else if (wd_expire) state_next = pkt_ok ? ARMED : UNSYNC;
      end
      SYNC:    if (wd_expire) state_next = pkt_ok ? ARMED : UNSYNC;
      default: state_next = UNSYNC;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tod       <= TOD_RESET;
      shadow    <= '0;
      load_pend <= 1'b0;
      o_tick    <= 1'b0;
      o_resync  <= 1'b0;
      o_pkt_err <= 1'b0;
      o_locked  <= 1'b0;
    end else begin
      o_tick    <= pps_load | pps_step;
      o_resync  <= 1'b0;
      o_pkt_err <= pkt_evt & ~pkt_valid;
      o_locked  <= (state_next == SYNC);
      if (pps_load) begin
        tod      <= shadow_inc;
        o_resync <= (state == SYNC) && (shadow_inc != tod_step);
      end else if (pps_step) begin
        tod <= tod_step;
      end
      if (pkt_ok) shadow <= pkt;
      if (pkt_ok)                     load_pend <= 1'b1;
      else if (pps_load || wd_expire) load_pend <= 1'b0;
    end
  end

  assign o_year    = tod.year;
  assign o_month   = tod.month;
  assign o_day     = tod.day;
  assign o_hour    = tod.hour;
  assign o_minutes = tod.minutes;
  assign o_seconds = tod.seconds;

endmodule

// File: tb/tb_thunder_tod_keeper.sv
// Bench for thunder_tod_keeper: directed scenarios plus randomized packets/PPS,
// scored against a seconds-since-2000 calendar model.
module tb_thunder_tod_keeper;

  localparam int TIMEOUT = 400;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_pps = 1'b0;
  logic        i_dv  = 1'b0;
  logic [7:0]  yh = '0, yl = '0, mo = '0, dd = '0, hh = '0, mi = '0, ss = '0;
  logic [15:0] o_year;
  logic [7:0]  o_month, o_day, o_hour, o_minutes, o_seconds;
  logic        o_tick, o_locked, o_resync, o_pkt_err;
  logic [55:0] dut_tod;

  thunder_tod_keeper #(.CLK_FREQ_HZ(1000), .PPS_TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pps(i_pps), .i_thunder_packet_dv(i_dv),
    .i_thunder_year_h(yh), .i_thunder_year_l(yl), .i_thunder_month(mo),
    .i_thunder_day(dd), .i_thunder_hour(hh), .i_thunder_minutes(mi),
    .i_thunder_seconds(ss),
    .o_year(o_year), .o_month(o_month), .o_day(o_day), .o_hour(o_hour),
    .o_minutes(o_minutes), .o_seconds(o_seconds),
    .o_tick(o_tick), .o_locked(o_locked), .o_resync(o_resync), .o_pkt_err(o_pkt_err)
  );

  always #5 i_clk = ~i_clk;
  assign dut_tod = {o_year, o_month, o_day, o_hour, o_minutes, o_seconds};

  typedef struct { int y, mo, d, h, mi, s; } tm_t;
  typedef struct { bit is_tick; tm_t t; bit resync; } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;

  // Reference model: lock/pending flags, shadow and current time.
  bit   m_locked = 0, m_pend = 0;
  tm_t  m_shadow, m_cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit leap(input int y);
    return (y % 4) == 0;
  endfunction

  function automatic int dim(input int y, input int m);
    case (m)
      4, 6, 9, 11: return 30;
      2:           return leap(y) ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  function automatic longint to_secs(input tm_t t);
    longint days = 0;
    for (int y = 2000; y < t.y; y++) days += leap(y) ? 366 : 365;
    for (int m = 1; m < t.mo; m++) days += dim(t.y, m);
    days += t.d - 1;
    return days * 86400 + t.h * 3600 + t.mi * 60 + t.s;
  endfunction

  function automatic tm_t from_secs(input longint s);
    tm_t    t;
    longint days = s / 86400;
    longint rem  = s % 86400;
    t.h  = int'(rem / 3600);
    t.mi = int'((rem % 3600) / 60);
    t.s  = int'(rem % 60);
    t.y  = 2000;
    while (days >= (leap(t.y) ? 366 : 365)) begin
      days -= leap(t.y) ? 366 : 365;
      t.y++;
    end
    t.mo = 1;
    while (days >= dim(t.y, t.mo)) begin
      days -= dim(t.y, t.mo);
      t.mo++;
    end
    t.d = int'(days) + 1;
    return t;
  endfunction

  function automatic tm_t add1(input tm_t t);
    return from_secs(to_secs(t) + 1);
  endfunction

  function automatic bit valid(input tm_t t);
    return t.y >= 2000 && t.y <= 2099 && t.mo >= 1 && t.mo <= 12 &&
           t.d >= 1 && t.d <= dim(t.y, t.mo) && t.h >= 0 && t.h <= 23 &&
           t.mi >= 0 && t.mi <= 59 && t.s >= 0 && t.s <= 59;
  endfunction

  function automatic logic [55:0] pack(input tm_t t);
    return {16'(t.y), 8'(t.mo), 8'(t.d), 8'(t.h), 8'(t.mi), 8'(t.s)};
  endfunction

  function automatic tm_t mk(input int y, m, d, h, n, s);
    tm_t t;
    t.y = y; t.mo = m; t.d = d; t.h = h; t.mi = n; t.s = s;
    return t;
  endfunction

  function automatic tm_t rand_valid();
    tm_t t;
    t.y  = 2000 + int'($urandom_range(0, 98));
    t.mo = int'($urandom_range(1, 12));
    t.d  = $urandom_range(0, 1) ? dim(t.y, t.mo) : int'($urandom_range(1, dim(t.y, t.mo)));
    t.h  = $urandom_range(0, 1) ? 23 : int'($urandom_range(0, 23));
    t.mi = $urandom_range(0, 1) ? 59 : int'($urandom_range(0, 59));
    t.s  = int'($urandom_range(50, 59));
    return t;
  endfunction

  function automatic tm_t rand_invalid();
    tm_t t = rand_valid();
    case ($urandom_range(0, 5))
      0: t.y  = $urandom_range(0, 1) ? 1999 : 2100 + int'($urandom_range(0, 50));
      1: t.mo = $urandom_range(0, 1) ? 0 : 13 + int'($urandom_range(0, 242));
      2: t.d  = $urandom_range(0, 1) ? 0 : dim(t.y, t.mo) + 1;
      3: t.h  = 24 + int'($urandom_range(0, 231));
      4: t.mi = 60 + int'($urandom_range(0, 195));
      default: t.s = 60 + int'($urandom_range(0, 195));
    endcase
    return t;
  endfunction

  task automatic model_pkt(input tm_t t);
    exp_t e;
    if (valid(t)) begin
      m_shadow = t;
      m_pend   = 1;
    end else begin
      e.is_tick = 0; e.t = t; e.resync = 0;
      sb.push_back(e);
    end
  endtask

  task automatic model_pps(output bit exp_tick, output bit exp_rs);
    exp_t e;
    tm_t  nxt;
    exp_tick = 0;
    exp_rs   = 0;
    if (m_pend) begin
      nxt    = add1(m_shadow);
      exp_rs = m_locked && (to_secs(nxt) != to_secs(add1(m_cur)));
      m_cur  = nxt;
      m_locked = 1;
      m_pend   = 0;
      exp_tick = 1;
    end else if (m_locked) begin
      m_cur    = add1(m_cur);
      exp_tick = 1;
    end
    if (exp_tick) begin
      e.is_tick = 1; e.t = m_cur; e.resync = exp_rs;
      sb.push_back(e);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_pend   = 0;
    m_cur    = mk(2000, 1, 1, 0, 0, 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic set_fields(input tm_t t);
    yh = 8'(t.y >> 8); yl = 8'(t.y); mo = 8'(t.mo); dd = 8'(t.d);
    hh = 8'(t.h); mi = 8'(t.mi); ss = 8'(t.s);
  endtask

  task automatic send_pkt(input tm_t t);
    model_pkt(t);
    set_fields(t);
    i_dv = 1;
    cyc(int'($urandom_range(1, 3)));
    i_dv = 0;
    cyc(3);
  endtask

  task automatic pulse_pps();
    bit et, er;
    model_pps(et, er);
    i_pps = 1;
    cyc(3);
    chk("tick_too_early", 64'(o_tick), 64'd0);
    i_pps = 0;
    cyc(1);
    chk("pps_tick", 64'(o_tick), 64'(et));
    chk("pps_resync", 64'(o_resync), 64'(er));
    cyc(4);
  endtask

  // Packet event lands in the same cycle as the internal PPS event.
  task automatic pps_with_pkt(input tm_t t);
    bit et, er;
    model_pps(et, er);
    model_pkt(t);
    i_pps = 1;
    cyc(3);
    i_pps = 0;
    set_fields(t);
    i_dv = 1;
    cyc(1);
    chk("same_cycle_tick", 64'(o_tick), 64'(et));
    i_dv = 0;
    cyc(4);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tod"}, 64'(dut_tod), 64'(pack(mk(2000, 1, 1, 0, 0, 0))));
    chk({tag, "_flags"}, 64'({o_tick, o_locked, o_resync, o_pkt_err}), 64'd0);
  endtask

  task automatic do_reset();
    i_rst = 0;
    cyc(2);
    model_reset();
    i_rst = 1;
    cyc(2);
  endtask

  always @(negedge i_clk) begin
    if (o_tick || o_pkt_err) begin
      if (sb.size() == 0) chk("unexpected_event", {62'd0, o_tick, o_pkt_err}, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("event_kind", {62'd0, o_tick, o_pkt_err}, mon_e.is_tick ? 64'd2 : 64'd1);
        if (mon_e.is_tick) begin
          chk("tod", 64'(dut_tod), 64'(pack(mon_e.t)));
          chk("resync", 64'(o_resync), 64'(mon_e.resync));
          chk("locked_on_tick", 64'(o_locked), 64'd1);
        end
      end
    end else if (o_resync) begin
      chk("resync_without_tick", 64'(o_resync), 64'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int since_pps;
    int r;
    model_reset();
    cyc(3);
    chk_reset_vals("reset");
    i_rst = 1;
    cyc(2);
    pulse_pps();

    // Leap-day rollover from ARMED.
    send_pkt(mk(2024, 2, 28, 23, 59, 59));
    pulse_pps();
    chk("leap_day", 64'(dut_tod), 64'(pack(mk(2024, 2, 29, 0, 0, 0))));
    chk("leap_locked", 64'(o_locked), 64'd1);

    // New-year rollover, two PPS, no resync expected.
    do_reset();
    send_pkt(mk(2023, 12, 31, 23, 59, 58));
    pulse_pps();
    pulse_pps();
    chk("new_year", 64'(dut_tod), 64'(pack(mk(2024, 1, 1, 0, 0, 0))));

    // Invalid month rejected; stays unlocked.
    do_reset();
    send_pkt(mk(2024, 13, 1, 0, 0, 0));
    pulse_pps();
    chk("bad_pkt_unlocked", 64'(o_locked), 64'd0);

    // Free-run versus resync in SYNC.
    do_reset();
    send_pkt(mk(2024, 5, 10, 11, 59, 59));
    pulse_pps();
    pulse_pps();
    chk("free_run", 64'(dut_tod), 64'(pack(mk(2024, 5, 10, 12, 0, 1))));
    send_pkt(mk(2024, 5, 10, 12, 0, 5));
    pulse_pps();
    chk("resync_load", 64'(dut_tod), 64'(pack(mk(2024, 5, 10, 12, 0, 6))));

    // Same-cycle packet: old state drives this PPS, new packet waits.
    pps_with_pkt(mk(2024, 5, 10, 12, 30, 0));
    chk("same_cycle_step", 64'(dut_tod), 64'(pack(mk(2024, 5, 10, 12, 0, 7))));
    pulse_pps();
    chk("same_cycle_next", 64'(dut_tod), 64'(pack(mk(2024, 5, 10, 12, 30, 1))));

    // PPS loss.
    cyc(TIMEOUT + 20);
    m_locked = 0;
    m_pend   = 0;
    chk("timeout_unlock", 64'(o_locked), 64'd0);
    chk("timeout_frozen", 64'(dut_tod), 64'(pack(m_cur)));
    pulse_pps();
    chk("timeout_still_frozen", 64'(dut_tod), 64'(pack(m_cur)));
    send_pkt(mk(2030, 7, 4, 8, 0, 0));
    pulse_pps();

    // Async reset mid-SYNC with PPS high; no spurious tick after release.
    i_pps = 1;
    cyc(1);
    #2 i_rst = 0;
    #1 chk_reset_vals("async_reset");
    cyc(2);
    model_reset();
    i_rst = 1;
    send_pkt(mk(2031, 1, 1, 0, 0, 0));
    cyc(8);
    chk("release_no_lock", 64'(o_locked), 64'd0);
    i_pps = 0;
    cyc(3);
    pulse_pps();

    since_pps = 0;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (since_pps >= 6 || r < 4) begin
        pulse_pps();
        since_pps = 0;
      end else if (r < 7) begin
        send_pkt(rand_valid());
        since_pps++;
      end else if (r < 9) begin
        send_pkt(rand_invalid());
        since_pps++;
      end else begin
        pps_with_pkt(rand_valid());
        since_pps = 0;
      end
    end

    cyc(10);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
